// File: rtl/mem_access_unit.sv
// Memory-stage access unit: LDD/STD, PUSH/POP and two-word CALL/RET
// against a 2^ADDR_W x 16 data memory with a downward-growing stack.
//
// Ports:
//   Clk, Rst           clock, synchronous active-high reset
//   OpValid, Op        operation handshake and code
//                      (1 LDD, 2 STD, 3 PUSH, 4 POP, 5 CALL, 6 RET, else NOP)
//   EaAddr, StoreData  LDD/STD address, STD/PUSH data
//   PcIn               return PC for CALL
//   MemDataOut         asynchronous read data from the data memory
//   MemRead, MemWrite  data memory strobes (write on rising edge)
//   MemAddr, MemDataIn data memory address and write data
//   Busy               no new op can be accepted this cycle
//   Done, LoadData     completion pulse and LDD/POP result
//   PcOut, PcValid     RET target and its valid pulse
//   Sp, StackFault     stack pointer and sticky wrap flag
module mem_access_unit #(
    parameter int              ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              OpValid,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] EaAddr,
    input  logic [15:0]       StoreData,
    input  logic [31:0]       PcIn,
    input  logic [15:0]       MemDataOut,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemDataIn,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       LoadData,
    output logic [31:0]       PcOut,
    output logic              PcValid,
    output logic [ADDR_W-1:0] Sp,
    output logic              StackFault
);

    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALL2 = 2'd1,
        RET2  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [15:0]       pc_lo;
    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] sp_dec;
    logic              accept;
    logic              is_ldd;
    logic              is_std;
    logic              is_push;
    logic              is_pop;
    logic              is_call;
    logic              is_ret;
    logic              in_call2;
    logic              in_ret2;
    logic              sp_dn;
    logic              sp_up;

    assign sp_inc   = Sp + ADDR_W'(1);
    assign sp_dec   = Sp - ADDR_W'(1);
    assign accept   = OpValid && (state == IDLE) && !Rst;
    assign is_ldd   = accept && (Op == OP_LDD);
    assign is_std   = accept && (Op == OP_STD);
    assign is_push  = accept && (Op == OP_PUSH);
    assign is_pop   = accept && (Op == OP_POP);
    assign is_call  = accept && (Op == OP_CALL);
    assign is_ret   = accept && (Op == OP_RET);
    assign in_call2 = (state == CALL2) && !Rst;
    assign in_ret2  = (state == RET2) && !Rst;
    assign sp_dn    = is_push || is_call || in_call2;
    assign sp_up    = is_pop || is_ret || in_ret2;
    assign Busy     = (state != IDLE);

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (is_call) begin
                    state_nxt = CALL2;
                end else if (is_ret) begin
                    state_nxt = RET2;
                end
            end
            CALL2:   state_nxt = IDLE;
            RET2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port outputs; Sp already moved by one in CALL2/RET2,
    // so the second word sits at Sp (CALL) or Sp+1 (RET).
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemAddr   = '0;
        MemDataIn = '0;
        if (is_ldd) begin
            MemRead = 1'b1;
            MemAddr = EaAddr;
        end else if (is_std) begin
            MemWrite  = 1'b1;
            MemAddr   = EaAddr;
            MemDataIn = StoreData;
        end else if (is_push) begin
            MemWrite  = 1'b1;
            MemAddr   = Sp;
            MemDataIn = StoreData;
        end else if (is_call) begin
            MemWrite  = 1'b1;
            MemAddr   = Sp;
            MemDataIn = PcIn[31:16];
        end else if (is_pop || is_ret || in_ret2) begin
            MemRead = 1'b1;
            MemAddr = sp_inc;
        end else if (in_call2) begin
            MemWrite  = 1'b1;
            MemAddr   = Sp;
            MemDataIn = pc_lo;
        end
    end

    // Datapath and status registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Sp         <= SP_RESET;
            StackFault <= 1'b0;
            Done       <= 1'b0;
            PcValid    <= 1'b0;
            LoadData   <= '0;
            PcOut      <= '0;
            pc_lo      <= '0;
        end else begin
            Done    <= is_ldd || is_std || is_push || is_pop ||
                       in_call2 || in_ret2;
            PcValid <= in_ret2;
            if (sp_dn) begin
                Sp <= sp_dec;
            end else if (sp_up) begin
                Sp <= sp_inc;
            end
            if ((sp_dn && (Sp == '0)) || (sp_up && (Sp == '1))) begin
                StackFault <= 1'b1;
            end
            if (is_ldd || is_pop) begin
                LoadData <= MemDataOut;
            end
            if (is_call) begin
                pc_lo <= PcIn[15:0];
            end
            if (is_ret) begin
                PcOut[15:0] <= MemDataOut;
            end
            if (in_ret2) begin
                PcOut[31:16] <= MemDataOut;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: data memory model, reference stack
// model and an in-order scoreboard of completion results.
module tb_mem_access_unit;

    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_STD  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        OpValid = 1'b0;
    logic [2:0]  Op = '0;
    logic [10:0] EaAddr = '0;
    logic [15:0] StoreData = '0;
    logic [31:0] PcIn = '0;
    logic [15:0] MemDataOut;
    logic        MemRead;
    logic        MemWrite;
    logic [10:0] MemAddr;
    logic [15:0] MemDataIn;
    logic        Busy;
    logic        Done;
    logic [15:0] LoadData;
    logic [31:0] PcOut;
    logic        PcValid;
    logic [10:0] Sp;
    logic        StackFault;

    mem_access_unit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .OpValid    (OpValid),
        .Op         (Op),
        .EaAddr     (EaAddr),
        .StoreData  (StoreData),
        .PcIn       (PcIn),
        .MemDataOut (MemDataOut),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .Busy       (Busy),
        .Done       (Done),
        .LoadData   (LoadData),
        .PcOut      (PcOut),
        .PcValid    (PcValid),
        .Sp         (Sp),
        .StackFault (StackFault)
    );

    always #5 Clk = ~Clk;

    // Data memory with a bench-side preload port
    logic [15:0] mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = '0;
    logic [15:0] pre_data = '0;
    int          std_hits = 0;
    logic        std_early = 1'b0;

    assign MemDataOut = mem[MemAddr];

    always @(posedge Clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (MemWrite) begin
            mem[MemAddr] <= MemDataIn;
        end
        if (MemWrite && MemAddr == 11'h020) begin
            std_hits <= std_hits + 1;
            if (Busy) begin
                std_early <= 1'b1;
            end
        end
    end

    // Reference model state
    logic [15:0] ref_mem [0:2047];
    logic [10:0] sp_m = 11'h7FF;
    logic        fault_m = 1'b0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int busy_cyc = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every Done pulse
    always @(negedge Clk) begin
        exp_t e;
        if (Busy) begin
            busy_cyc++;
        end
        if (MemRead && MemWrite) begin
            check("rdwr_excl", 32'd1, 32'd0);
        end
        if (PcValid && !Done) begin
            check("pcv_nodone", 32'd1, 32'd0);
        end
        if (Done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                check("done_unexp", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                if (e.op == OP_LDD || e.op == OP_POP) begin
                    check("loaddata", {16'h0, LoadData}, e.val);
                end else if (e.op == OP_RET) begin
                    check("pcout", PcOut, e.val);
                    check("pcvalid", {31'h0, PcValid}, 32'd1);
                end else begin
                    check("pcv_low", {31'h0, PcValid}, 32'd0);
                end
            end
        end
    end

    task automatic m_dec();
        if (sp_m == 11'h000) fault_m = 1'b1;
        sp_m = sp_m - 11'd1;
    endtask

    task automatic m_inc();
        if (sp_m == 11'h7FF) fault_m = 1'b1;
        sp_m = sp_m + 11'd1;
    endtask

    // Update the reference model for an accepted op and queue its result
    task automatic model(input logic [2:0] op, input logic [10:0] ea,
                         input logic [15:0] sd, input logic [31:0] pc);
        exp_t e;
        logic [15:0] lo;
        e.op  = op;
        e.val = '0;
        case (op)
            OP_LDD: e.val = {16'h0, ref_mem[ea]};
            OP_STD: ref_mem[ea] = sd;
            OP_PUSH: begin
                ref_mem[sp_m] = sd;
                m_dec();
            end
            OP_POP: begin
                m_inc();
                e.val = {16'h0, ref_mem[sp_m]};
            end
            OP_CALL: begin
                ref_mem[sp_m] = pc[31:16];
                m_dec();
                ref_mem[sp_m] = pc[15:0];
                m_dec();
            end
            OP_RET: begin
                m_inc();
                lo = ref_mem[sp_m];
                m_inc();
                e.val = {ref_mem[sp_m], lo};
            end
            default: ;
        endcase
        if (op >= OP_LDD && op <= OP_RET) begin
            sbq.push_back(e);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [10:0] ea,
                         input logic [15:0] sd, input logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        @(negedge Clk);
        OpValid   = 1'b1;
        Op        = op;
        EaAddr    = ea;
        StoreData = sd;
        PcIn      = pc;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (!Busy) begin
                @(posedge Clk);
                model(op, ea, sd, pc);
                ok = 1'b1;
            end else begin
                @(negedge Clk);
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end
        #1;
        OpValid = 1'b0;
    endtask

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        @(negedge Clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge Clk);
        #1;
        pre_we     = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("rst_wr", {31'h0, MemWrite}, 32'd0);
        check("rst_rd", {31'h0, MemRead}, 32'd0);
        @(negedge Clk);
        Rst     = 1'b0;
        sp_m    = 11'h7FF;
        fault_m = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        int d0;
        int h0;
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_sp", {21'h0, Sp}, 32'h7FF);
        check("rst_busy", {31'h0, Busy}, 32'd0);
        check("rst_done", {31'h0, Done}, 32'd0);
        check("rst_ld", {16'h0, LoadData}, 32'd0);
        check("rst_pc", PcOut, 32'd0);
        check("rst_pcv", {31'h0, PcValid}, 32'd0);
        check("rst_fault", {31'h0, StackFault}, 32'd0);
        check("rst_wr", {31'h0, MemWrite}, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        // STD then LDD
        d0 = done_cnt;
        do_op(OP_STD, 11'h010, 16'h1234, 32'h0);
        do_op(OP_LDD, 11'h010, 16'h0, 32'h0);
        settle();
        check("ldst_done", done_cnt - d0, 32'd2);
        check("std_mem", {16'h0, mem[11'h010]}, 32'h1234);

        // NOP codes produce nothing
        d0 = done_cnt;
        do_op(3'd0, 11'h0, 16'h0, 32'h0);
        do_op(3'd7, 11'h0, 16'h0, 32'h0);
        settle();
        check("nop_done", done_cnt - d0, 32'd0);

        // Two pushes, two pops
        do_op(OP_PUSH, 11'h0, 16'hAAAA, 32'h0);
        do_op(OP_PUSH, 11'h0, 16'h5555, 32'h0);
        settle();
        check("push_m7ff", {16'h0, mem[11'h7FF]}, 32'hAAAA);
        check("push_m7fe", {16'h0, mem[11'h7FE]}, 32'h5555);
        check("push_sp", {21'h0, Sp}, 32'h7FD);
        do_op(OP_POP, 11'h0, 16'h0, 32'h0);
        do_op(OP_POP, 11'h0, 16'h0, 32'h0);
        settle();
        check("pop_sp", {21'h0, Sp}, 32'h7FF);

        // CALL / RET
        busy_cyc = 0;
        do_op(OP_CALL, 11'h0, 16'h0, 32'hDEAD_BEEF);
        settle();
        check("call_busy", busy_cyc, 32'd1);
        check("call_hi", {16'h0, mem[11'h7FF]}, 32'hDEAD);
        check("call_lo", {16'h0, mem[11'h7FE]}, 32'hBEEF);
        check("call_sp", {21'h0, Sp}, 32'h7FD);
        busy_cyc = 0;
        do_op(OP_RET, 11'h0, 16'h0, 32'h0);
        settle();
        check("ret_busy", busy_cyc, 32'd1);
        check("ret_sp", {21'h0, Sp}, 32'h7FF);
        check("ret_pc", PcOut, 32'hDEAD_BEEF);
        check("nofault", {31'h0, StackFault}, 32'd0);

        // POP past the top wraps to address 0
        preload(11'h000, 16'h0BAD);
        do_op(OP_POP, 11'h0, 16'h0, 32'h0);
        settle();
        check("wrap_sp", {21'h0, Sp}, 32'h000);
        check("wrap_fault", {31'h0, StackFault}, {31'h0, fault_m});
        check("wrap_ld", {16'h0, LoadData}, 32'h0BAD);
        do_op(OP_PUSH, 11'h0, 16'h7777, 32'h0);
        settle();
        check("sticky_fault", {31'h0, StackFault}, 32'd1);
        check("wrap2_sp", {21'h0, Sp}, {21'h0, sp_m});
        check("wrap2_mem", {16'h0, mem[11'h000]}, 32'h7777);

        // Reset during CALL2 aborts the second write
        do_reset();
        check("rst2_fault", {31'h0, StackFault}, 32'd0);
        preload(11'h7FE, 16'hCCCC);
        @(negedge Clk);
        OpValid = 1'b1;
        Op      = OP_CALL;
        PcIn    = 32'h1111_2222;
        @(posedge Clk);
        ref_mem[11'h7FF] = 16'h1111;
        #1;
        check("abort_busy1", {31'h0, Busy}, 32'd1);
        @(negedge Clk);
        OpValid = 1'b0;
        Rst     = 1'b1;
        #1;
        check("abort_wr", {31'h0, MemWrite}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("abort_sp", {21'h0, Sp}, 32'h7FF);
        check("abort_done", {31'h0, Done}, 32'd0);
        check("abort_busy", {31'h0, Busy}, 32'd0);
        check("abort_lo", {16'h0, mem[11'h7FE]}, 32'hCCCC);
        check("abort_hi", {16'h0, mem[11'h7FF]}, 32'h1111);
        settle();
        check("abort_pcv", {31'h0, PcValid}, 32'd0);

        // STD held through CALL2 executes once, after Busy drops
        d0 = done_cnt;
        h0 = std_hits;
        do_op(OP_CALL, 11'h0, 16'h0, 32'hCAFE_F00D);
        do_op(OP_STD, 11'h020, 16'h4321, 32'h0);
        settle();
        check("hold_hits", std_hits - h0, 32'd1);
        check("hold_early", {31'h0, std_early}, 32'd0);
        check("hold_mem", {16'h0, mem[11'h020]}, 32'h4321);
        check("hold_lo", {16'h0, mem[11'h7FE]}, 32'hF00D);
        check("hold_hi", {16'h0, mem[11'h7FF]}, 32'hCAFE);
        check("hold_sp", {21'h0, Sp}, 32'h7FD);
        check("hold_done", done_cnt - d0, 32'd2);

        check("sb_left", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
